// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: WIDTH-bit shift/rotate pipe, one stage per shamt bit, valid/ready with global stall.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 32,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction
  // index 0 is the input register; index k+1 holds the result of shift stage k
  logic [WIDTH-1:0] data_q [LOG2W+1];
  logic             left_q [LOG2W+1];
  logic             valid_q [LOG2W+1];
  logic [LOG2W-1:0] shamt_q [LOG2W];
  logic [1:0]       cls_q [LOG2W];
  logic             msb_q [LOG2W];
  logic [WIDTH-1:0] data_d [LOG2W];
  logic             advance;
  logic             left_in;
  assign out_valid = valid_q[LOG2W];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;
  assign left_in   = in_op == 3'd0 || in_op == 3'd3;
  assign out_data  = left_q[LOG2W] ? rev(data_q[LOG2W]) : data_q[LOG2W];
  assign out_zero  = out_valid && out_data == '0;
  // cls: 0 zero fill, 1 sign fill, 2 rotate
  for (genvar g = 0; g < LOG2W; g++) begin : g_stage
    localparam int N = 1 << (LOG2W - 1 - g);
    assign data_d[g] = !shamt_q[g][LOG2W-1-g] ? data_q[g] :
                       cls_q[g] == 2'd2 ? (data_q[g] >> N) | (data_q[g] << (WIDTH - N)) :
                       (cls_q[g] == 2'd1 && msb_q[g]) ? ~(~data_q[g] >> N) :
                       data_q[g] >> N;
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i <= LOG2W; i++) begin
        data_q[i]  <= '0;
        left_q[i]  <= 1'b0;
        valid_q[i] <= 1'b0;
      end
      for (int i = 0; i < LOG2W; i++) begin
        shamt_q[i] <= '0;
        cls_q[i]   <= '0;
        msb_q[i]   <= 1'b0;
      end
    end else if (advance) begin
      data_q[0]  <= left_in ? rev(in_data) : in_data;
      left_q[0]  <= left_in;
      valid_q[0] <= in_valid;
      shamt_q[0] <= in_op > 3'd4 ? '0 : in_shamt;
      cls_q[0]   <= in_op == 3'd2 ? 2'd1 : (in_op == 3'd3 || in_op == 3'd4) ? 2'd2 : 2'd0;
      msb_q[0]   <= in_data[WIDTH-1];
      for (int i = 0; i < LOG2W; i++) begin
        data_q[i+1]  <= data_d[i];
        left_q[i+1]  <= left_q[i];
        valid_q[i+1] <= valid_q[i];
      end
      for (int i = 1; i < LOG2W; i++) begin
        shamt_q[i] <= shamt_q[i-1];
        cls_q[i]   <= cls_q[i-1];
        msb_q[i]   <= msb_q[i-1];
      end
    end
endmodule
